ub_port_arbiter: RTL and testbench

//  Shares the single-port Unified Buffer SRAM between two requesters.

---
 rtl/ub_port_arbiter.sv | 110 +++++++++++
 tb/tb_ub_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_port_arbiter.sv
// Shares the single-port Unified Buffer SRAM between the host/DMA load path and the
// systolic-array path using burst-limited round-robin, one SRAM access per cycle.
module ub_port_arbiter #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 64,
    parameter int MAX_BURST   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   h_req_valid,
    output logic                   h_req_ready,
    input  logic                   h_req_we,
    input  logic [ADDRESSSIZE-1:0] h_req_addr,
    input  logic [WORDSIZE-1:0]    h_req_wdata,
    output logic                   h_rsp_valid,
    input  logic                   a_req_valid,
    output logic                   a_req_ready,
    input  logic                   a_req_we,
    input  logic [ADDRESSSIZE-1:0] a_req_addr,
    input  logic [WORDSIZE-1:0]    a_req_wdata,
    output logic                   a_rsp_valid,
    output logic [WORDSIZE-1:0]    rsp_rdata,
    output logic                   sram_we,
    output logic [ADDRESSSIZE-1:0] sram_addr,
    output logic [WORDSIZE-1:0]    sram_wdata,
    input  logic [WORDSIZE-1:0]    sram_rdata
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic {
        OWNER_HOST  = 1'b0,
        OWNER_ARRAY = 1'b1
    } owner_t;

    owner_t        owner;
    logic [CW-1:0] cnt;
    logic          grant_h;
    logic          grant_a;
    logic          rsp_h_q;
    logic          rsp_a_q;

    // The owner keeps the port until its burst budget is spent, but only while the other side waits.
    always_comb begin
        grant_h = 1'b0;
        grant_a = 1'b0;
        if (!rst) begin
            if (h_req_valid && a_req_valid) begin
                if (cnt < CNT_MAX) begin
                    grant_h = (owner == OWNER_HOST);
                    grant_a = (owner == OWNER_ARRAY);
                end else begin
                    grant_h = (owner == OWNER_ARRAY);
                    grant_a = (owner == OWNER_HOST);
                end
            end else begin
                grant_h = h_req_valid;
                grant_a = a_req_valid;
            end
        end
    end

    assign h_req_ready = grant_h;
    assign a_req_ready = grant_a;

    // An idle port issues a harmless read of address 0; no response is tracked for it.
    always_comb begin
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_h) begin
            sram_we    = h_req_we;
            sram_addr  = h_req_addr;
            sram_wdata = h_req_wdata;
        end else if (grant_a) begin
            sram_we    = a_req_we;
            sram_addr  = a_req_addr;
            sram_wdata = a_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= OWNER_HOST;
            cnt     <= '0;
            rsp_h_q <= 1'b0;
            rsp_a_q <= 1'b0;
        end else begin
            rsp_h_q <= grant_h && !h_req_we;
            rsp_a_q <= grant_a && !a_req_we;
            if (grant_h || grant_a) begin
                if ((grant_h && owner == OWNER_HOST) || (grant_a && owner == OWNER_ARRAY)) begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end else begin
                    owner <= grant_h ? OWNER_HOST : OWNER_ARRAY;
                    cnt   <= CW'(1);
                end
            end
        end
    end

    // Gating with rst drops a response whose read was granted just before reset arrived.
    assign h_rsp_valid = rsp_h_q && !rst;
    assign a_rsp_valid = rsp_a_q && !rst;
    assign rsp_rdata   = sram_rdata;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Directed bench for ub_port_arbiter: one instance with MAX_BURST=4 and one with MAX_BURST=1,
// each attached to a small registered-read SRAM model.
module tb_ub_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam logic [DW-1:0] INIT_TAG = 64'hC0DE_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          h_req_valid, h_req_ready, h_req_we, h_rsp_valid;
    logic [AW-1:0] h_req_addr;
    logic [DW-1:0] h_req_wdata;
    logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic [DW-1:0] rsp_rdata, sram_wdata, sram_rdata;
    logic          sram_we;
    logic [AW-1:0] sram_addr;

    logic          m_h_req_valid, m_h_req_ready, m_h_rsp_valid;
    logic [AW-1:0] m_h_req_addr;
    logic          m_a_req_valid, m_a_req_ready, m_a_rsp_valid;
    logic [AW-1:0] m_a_req_addr;
    logic [DW-1:0] m_rsp_rdata, m_sram_wdata, m_sram_rdata;
    logic          m_sram_we;
    logic [AW-1:0] m_sram_addr;

    int errors = 0;
    int checks = 0;

    ub_port_arbiter #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_we(h_req_we),
        .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata), .h_rsp_valid(h_rsp_valid),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
        .rsp_rdata(rsp_rdata), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    ub_port_arbiter #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .MAX_BURST(1)) dut_alt (
        .clk(clk), .rst(rst),
        .h_req_valid(m_h_req_valid), .h_req_ready(m_h_req_ready), .h_req_we(1'b0),
        .h_req_addr(m_h_req_addr), .h_req_wdata('0), .h_rsp_valid(m_h_rsp_valid),
        .a_req_valid(m_a_req_valid), .a_req_ready(m_a_req_ready), .a_req_we(1'b0),
        .a_req_addr(m_a_req_addr), .a_req_wdata('0), .a_rsp_valid(m_a_rsp_valid),
        .rsp_rdata(m_rsp_rdata), .sram_we(m_sram_we), .sram_addr(m_sram_addr),
        .sram_wdata(m_sram_wdata), .sram_rdata(m_sram_rdata)
    );

    // Unwritten words read back as INIT_TAG | address so read data is predictable.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] addr);
        return INIT_TAG | DW'(addr);
    endfunction

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_we) begin
            mem[sram_addr]     <= sram_wdata;
            written[sram_addr] <= 1'b1;
        end
        sram_rdata <= (written[sram_addr] === 1'b1) ? mem[sram_addr] : init_word(sram_addr);
    end

    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    logic          m_written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (m_sram_we) begin
            m_mem[m_sram_addr]     <= m_sram_wdata;
            m_written[m_sram_addr] <= 1'b1;
        end
        m_sram_rdata <= (m_written[m_sram_addr] === 1'b1) ? m_mem[m_sram_addr] : init_word(m_sram_addr);
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle on the MAX_BURST=4 instance, then waits to the falling edge for checks.
    task automatic applyStimulus(input logic r,
                                 input logic hv, input logic hwe, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                                 input logic av, input logic awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        @(posedge clk);
        #1;
        rst         = r;
        h_req_valid = hv;
        h_req_we    = hwe;
        h_req_addr  = ha;
        h_req_wdata = hd;
        a_req_valid = av;
        a_req_we    = awe;
        a_req_addr  = aa;
        a_req_wdata = ad;
        @(negedge clk);
    endtask

    // Same as applyStimulus but for the MAX_BURST=1 instance (reads only).
    task automatic applyStimulusAlt(input logic r, input logic hv, input logic [AW-1:0] ha,
                                    input logic av, input logic [AW-1:0] aa);
        @(posedge clk);
        #1;
        rst           = r;
        m_h_req_valid = hv;
        m_h_req_addr  = ha;
        m_a_req_valid = av;
        m_a_req_addr  = aa;
        @(negedge clk);
    endtask

    initial begin
        string    grants;
        logic     exp_h;
        logic     prev_h;
        logic [AW-1:0] addr;

        h_req_valid = 0; h_req_we = 0; h_req_addr = '0; h_req_wdata = '0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
        m_h_req_valid = 0; m_h_req_addr = '0; m_a_req_valid = 0; m_a_req_addr = '0;

        // Reset with both requesting writes: nothing may be granted or written.
        applyStimulus(1, 1, 1, 10'h3FF, 64'hFFFF, 1, 1, 10'h2AA, 64'h1);
        checkOutput("rst_h_ready", DW'(h_req_ready), 0);
        checkOutput("rst_a_ready", DW'(a_req_ready), 0);
        checkOutput("rst_sram_we", DW'(sram_we), 0);
        checkOutput("rst_sram_addr", DW'(sram_addr), 0);
        checkOutput("rst_h_rsp", DW'(h_rsp_valid), 0);
        checkOutput("rst_a_rsp", DW'(a_rsp_valid), 0);
        applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0);
        checkOutput("rst2_h_rsp", DW'(h_rsp_valid), 0);
        checkOutput("rst2_a_rsp", DW'(a_rsp_valid), 0);

        // Host write then array read of the same word.
        applyStimulus(0, 1, 1, 10'h005, 64'h0123456789ABCDEF, 0, 0, '0, '0);
        checkOutput("t1_h_ready", DW'(h_req_ready), 1);
        checkOutput("t1_a_ready", DW'(a_req_ready), 0);
        checkOutput("t1_sram_we", DW'(sram_we), 1);
        checkOutput("t1_sram_addr", DW'(sram_addr), 64'h005);
        checkOutput("t1_sram_wdata", sram_wdata, 64'h0123456789ABCDEF);
        applyStimulus(0, 0, 0, '0, '0, 1, 0, 10'h005, '0);
        checkOutput("t1_a_ready_rd", DW'(a_req_ready), 1);
        checkOutput("t1_sram_we_rd", DW'(sram_we), 0);
        checkOutput("t1_sram_addr_rd", DW'(sram_addr), 64'h005);
        checkOutput("t1_h_rsp_after_wr", DW'(h_rsp_valid), 0);
        applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0);
        checkOutput("t1_a_rsp", DW'(a_rsp_valid), 1);
        checkOutput("t1_rdata", rsp_rdata, 64'h0123456789ABCDEF);
        checkOutput("t1_h_rsp", DW'(h_rsp_valid), 0);
        checkOutput("t1_idle_addr", DW'(sram_addr), 0);

        // Both requesters reading continuously from reset.
        applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0);
        grants = "HHHHAAAAHH";
        prev_h = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 10'h010, '0, 1, 0, 10'h020, '0);
            exp_h = (grants[i] == "H");
            checkOutput($sformatf("t2_h_ready[%0d]", i), DW'(h_req_ready), DW'(exp_h));
            checkOutput($sformatf("t2_a_ready[%0d]", i), DW'(a_req_ready), DW'(!exp_h));
            checkOutput($sformatf("t2_addr[%0d]", i), DW'(sram_addr), exp_h ? 64'h010 : 64'h020);
            if (i == 0) begin
                checkOutput("t2_h_rsp[0]", DW'(h_rsp_valid), 0);
                checkOutput("t2_a_rsp[0]", DW'(a_rsp_valid), 0);
            end else begin
                checkOutput($sformatf("t2_h_rsp[%0d]", i), DW'(h_rsp_valid), DW'(prev_h));
                checkOutput($sformatf("t2_a_rsp[%0d]", i), DW'(a_rsp_valid), DW'(!prev_h));
                checkOutput($sformatf("t2_rdata[%0d]", i), rsp_rdata,
                            prev_h ? init_word(10'h010) : init_word(10'h020));
            end
            prev_h = exp_h;
        end

        // Array alone: eight back-to-back reads.
        for (int j = 0; j < 8; j++) begin
            addr = 10'h100 + AW'(j);
            applyStimulus(0, 0, 0, '0, '0, 1, 0, addr, '0);
            checkOutput($sformatf("t3_a_ready[%0d]", j), DW'(a_req_ready), 1);
            checkOutput($sformatf("t3_h_ready[%0d]", j), DW'(h_req_ready), 0);
            checkOutput($sformatf("t3_addr[%0d]", j), DW'(sram_addr), DW'(addr));
            checkOutput($sformatf("t3_a_rsp[%0d]", j), DW'(a_rsp_valid), DW'(j > 0));
            checkOutput($sformatf("t3_h_rsp[%0d]", j), DW'(h_rsp_valid), DW'(j == 0));
            checkOutput($sformatf("t3_rdata[%0d]", j), rsp_rdata,
                        (j == 0) ? init_word(10'h010) : init_word(addr - 10'h1));
        end
        applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0);
        checkOutput("t3_a_rsp_last", DW'(a_rsp_valid), 1);
        checkOutput("t3_rdata_last", rsp_rdata, init_word(10'h107));

        // Idle with write strobes but no valid: port must stay quiet.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 10'h155, 64'hDEAD, 0, 1, 10'h0AA, 64'hBEEF);
            checkOutput($sformatf("t6_sram_we[%0d]", k), DW'(sram_we), 0);
            checkOutput($sformatf("t6_sram_addr[%0d]", k), DW'(sram_addr), 0);
            checkOutput($sformatf("t6_sram_wdata[%0d]", k), sram_wdata, 0);
            checkOutput($sformatf("t6_h_rsp[%0d]", k), DW'(h_rsp_valid), 0);
            checkOutput($sformatf("t6_a_rsp[%0d]", k), DW'(a_rsp_valid), 0);
        end

        // Array owns with a spent budget, so host wins; reset then drops its response.
        applyStimulus(0, 1, 0, 10'h030, '0, 1, 0, 10'h031, '0);
        checkOutput("t5_h_ready", DW'(h_req_ready), 1);
        checkOutput("t5_a_ready", DW'(a_req_ready), 0);
        checkOutput("t5_addr", DW'(sram_addr), 64'h030);
        applyStimulus(1, 1, 0, 10'h030, '0, 1, 0, 10'h031, '0);
        checkOutput("t5_rst_h_rsp", DW'(h_rsp_valid), 0);
        checkOutput("t5_rst_a_rsp", DW'(a_rsp_valid), 0);
        checkOutput("t5_rst_h_ready", DW'(h_req_ready), 0);
        checkOutput("t5_rst_a_ready", DW'(a_req_ready), 0);
        applyStimulus(0, 1, 0, 10'h030, '0, 1, 0, 10'h031, '0);
        checkOutput("t5_post_h_ready", DW'(h_req_ready), 1);
        checkOutput("t5_post_a_ready", DW'(a_req_ready), 0);
        checkOutput("t5_post_h_rsp", DW'(h_rsp_valid), 0);

        // Array takes ownership, then reset must hand it back to host with a fresh budget.
        applyStimulus(0, 0, 0, '0, '0, 1, 0, 10'h032, '0);
        checkOutput("t5b_a_ready", DW'(a_req_ready), 1);
        checkOutput("t5b_h_rsp", DW'(h_rsp_valid), 1);
        checkOutput("t5b_rdata", rsp_rdata, init_word(10'h030));
        applyStimulus(1, 1, 0, 10'h033, '0, 1, 0, 10'h034, '0);
        checkOutput("t5b_rst_a_rsp", DW'(a_rsp_valid), 0);
        for (int n = 0; n < 5; n++) begin
            applyStimulus(0, 1, 0, 10'h033, '0, 1, 0, 10'h034, '0);
            checkOutput($sformatf("t5b_h_ready[%0d]", n), DW'(h_req_ready), DW'(n < 4));
            checkOutput($sformatf("t5b_a_ready[%0d]", n), DW'(a_req_ready), DW'(n == 4));
        end

        // MAX_BURST=1 instance: strict alternation with per-requester responses.
        applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0);
        grants = "HAHAHA";
        prev_h = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulusAlt(0, 1, 10'h040, 1, 10'h050);
            exp_h = (grants[i] == "H");
            checkOutput($sformatf("t4_h_ready[%0d]", i), DW'(m_h_req_ready), DW'(exp_h));
            checkOutput($sformatf("t4_a_ready[%0d]", i), DW'(m_a_req_ready), DW'(!exp_h));
            checkOutput($sformatf("t4_addr[%0d]", i), DW'(m_sram_addr), exp_h ? 64'h040 : 64'h050);
            if (i == 0) begin
                checkOutput("t4_h_rsp[0]", DW'(m_h_rsp_valid), 0);
                checkOutput("t4_a_rsp[0]", DW'(m_a_rsp_valid), 0);
            end else begin
                checkOutput($sformatf("t4_h_rsp[%0d]", i), DW'(m_h_rsp_valid), DW'(prev_h));
                checkOutput($sformatf("t4_a_rsp[%0d]", i), DW'(m_a_rsp_valid), DW'(!prev_h));
                checkOutput($sformatf("t4_rdata[%0d]", i), m_rsp_rdata,
                            prev_h ? init_word(10'h040) : init_word(10'h050));
            end
            prev_h = exp_h;
        end
        applyStimulusAlt(0, 0, '0, 0, '0);
        checkOutput("t4_a_rsp_last", DW'(m_a_rsp_valid), 1);
        checkOutput("t4_h_rsp_last", DW'(m_h_rsp_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
